// File: rtl/io_input_ctrl.sv
// io_input_ctrl: two-port debounced input controller with CPU read decode.
// Each 32-bit port is sampled every cycle, debounced by its own FSM over a
// DEBOUNCE_CYCLES stability window, and committed into a readable register
// that raises a sticky change flag. Reading a port's data register clears
// its flag; reading the status register clears nothing.
// Optional feature macro: IO_INPUT_IRQ_EN drives io_irq from the change
// flags; when undefined io_irq is tied low and the flags still operate.
module io_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic        io_clk,
  input  logic        reset,
  input  logic [31:0] in_port0,
  input  logic [31:0] in_port1,
  input  logic [31:0] addr,
  input  logic        rd,
  output logic [31:0] io_read_data,
  output logic        io_irq
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_MAX = 255;
  localparam int unsigned N_PORTS = 2;

  localparam logic [5:0] SEL_STAB0  = 6'b100000;
  localparam logic [5:0] SEL_STAB1  = 6'b100001;
  localparam logic [5:0] SEL_STATUS = 6'b100010;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } state_e;

  state_e                            state_q [N_PORTS];
  state_e                            state_d [N_PORTS];
  logic [N_PORTS-1:0][DATA_W-1:0]    sample_q, sample_d;
  logic [N_PORTS-1:0][DATA_W-1:0]    cand_q, cand_d;
  logic [N_PORTS-1:0][DATA_W-1:0]    stab_q, stab_d;
  logic [N_PORTS-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_PORTS-1:0]                chg_q, chg_d;
  logic [N_PORTS-1:0]                commit_c;
  logic [N_PORTS-1:0]                clr_c;
  logic                              unused_addr;

  // Only addr[7:2] participates in the decode.
  assign unused_addr = ^{addr[31:8], addr[1:0]};

  // Per-port debounce next-state: restart on any change, drop on bounce-back,
  // commit once the candidate has been seen for DEBOUNCE_CYCLES cycles.
  always_comb begin : fsm_next
    sample_d = {in_port1, in_port0};
    for (int p = 0; p < int'(N_PORTS); p++) begin
      state_d[p]  = state_q[p];
      cnt_d[p]    = cnt_q[p];
      cand_d[p]   = cand_q[p];
      stab_d[p]   = stab_q[p];
      commit_c[p] = 1'b0;
      case (state_q[p])
        ST_STABLE: begin
          if (sample_q[p] != stab_q[p]) begin
            cand_d[p] = sample_q[p];
            cnt_d[p]  = CNT_W'(1);
            // A one-cycle window is already satisfied by the first sighting.
            if (DEBOUNCE_CYCLES <= 1) begin
              stab_d[p]   = sample_q[p];
              commit_c[p] = 1'b1;
            end else begin
              state_d[p] = ST_SETTLING;
            end
          end
        end
        ST_SETTLING: begin
          if (sample_q[p] != cand_q[p]) begin
            cand_d[p] = sample_q[p];
            cnt_d[p]  = CNT_W'(1);
          end else if (cand_q[p] == stab_q[p]) begin
            state_d[p] = ST_STABLE;
          end else if ((9'({1'b0, cnt_q[p]}) + 9'd1) >= 9'(DEBOUNCE_CYCLES)) begin
            stab_d[p]   = cand_q[p];
            commit_c[p] = 1'b1;
            state_d[p]  = ST_STABLE;
          end else if (cnt_q[p] != CNT_W'(CNT_MAX)) begin
            cnt_d[p] = cnt_q[p] + CNT_W'(1);
          end
        end
        default: state_d[p] = ST_STABLE;
      endcase
    end
  end

  // Read-side flag clears; a commit on the same edge overrides the clear.
  always_comb begin : flag_next
    clr_c    = '0;
    clr_c[0] = rd && (addr[7:2] == SEL_STAB0);
    clr_c[1] = rd && (addr[7:2] == SEL_STAB1);
    chg_d    = commit_c | (chg_q & ~clr_c);
  end

  // State registers with synchronous reset.
  always_ff @(posedge io_clk) begin
    if (reset) begin
      for (int p = 0; p < int'(N_PORTS); p++) begin
        state_q[p] <= ST_STABLE;
      end
      sample_q <= '0;
      cand_q   <= '0;
      stab_q   <= '0;
      cnt_q    <= '0;
      chg_q    <= '0;
    end else begin
      for (int p = 0; p < int'(N_PORTS); p++) begin
        state_q[p] <= state_d[p];
      end
      sample_q <= sample_d;
      cand_q   <= cand_d;
      stab_q   <= stab_d;
      cnt_q    <= cnt_d;
      chg_q    <= chg_d;
    end
  end

  // Combinational read decode of pre-edge register state.
  always_comb begin : read_mux
    io_read_data = '0;
    if (!reset) begin
      case (addr[7:2])
        SEL_STAB0:  io_read_data = stab_q[0];
        SEL_STAB1:  io_read_data = stab_q[1];
        SEL_STATUS: io_read_data = {30'b0, chg_q};
        default:    io_read_data = '0;
      endcase
    end
  end

`ifdef IO_INPUT_IRQ_EN
  logic irq_q, irq_d;

  // Interrupt level tracks the flags, taken from a flop so no input path exists.
  always_comb begin : irq_next
    irq_d = |chg_d;
  end

  // Interrupt register.
  always_ff @(posedge io_clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign io_irq = irq_q;
`else
  assign io_irq = 1'b0;
`endif

endmodule

// File: tb/tb_io_input_ctrl.sv
// tb_io_input_ctrl: scoreboard bench for io_input_ctrl (DEBOUNCE_CYCLES=4
// main instance plus a DEBOUNCE_CYCLES=1 instance sharing the stimulus).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_io_input_ctrl;

  logic        io_clk = 1'b0;
  logic        reset;
  logic [31:0] in_port0, in_port1, addr;
  logic        rd;
  logic [31:0] io_read_data, rd1_data;
  logic        io_irq, irq1;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got, got1, e;

  io_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .io_clk(io_clk), .reset(reset), .in_port0(in_port0), .in_port1(in_port1),
    .addr(addr), .rd(rd), .io_read_data(io_read_data), .io_irq(io_irq)
  );

  io_input_ctrl #(.DEBOUNCE_CYCLES(1)) dut1 (
    .io_clk(io_clk), .reset(reset), .in_port0(in_port0), .in_port1(in_port1),
    .addr(addr), .rd(rd), .io_read_data(rd1_data), .io_irq(irq1)
  );

  always #5 io_clk = ~io_clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic exp_irq(input logic f);
`ifdef IO_INPUT_IRQ_EN
    return f;
`else
    return 1'b0 & f;
`endif
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge io_clk);
  endtask

  // Present an address (optionally with rd) and capture both read buses.
  task automatic rd_bus(input logic [31:0] a, input logic r);
    addr = a;
    rd   = r;
    #1;
    got  = io_read_data;
    got1 = rd1_data;
    if (r) begin
      @(negedge io_clk);
      rd = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rd = 1'b0; addr = '0;
    in_port0 = 32'hFFFF_FFFF; in_port1 = 32'hFFFF_FFFF;
    idle(2);
    exp_q.push_back(32'h0); rd_bus(32'h80, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL rst_stab0 got=%h exp=%h", got, e); end
    exp_q.push_back(32'h0); rd_bus(32'h88, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL rst_status got=%h exp=%h", got, e); end
    checks++; if (io_irq !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b exp=0", io_irq); end
    reset = 1'b0; in_port0 = '0; in_port1 = '0;
    idle(3);
    exp_q.push_back(32'h0); rd_bus(32'h84, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL rst_stab1 got=%h exp=%h", got, e); end
  endtask

  task automatic test_clean_edge();
    in_port0 = 32'h0000_00A5;
    idle(1);
    exp_q.push_back(32'h0); rd_bus(32'h80, 1'b0);
    checks++; e = exp_q.pop_front(); if (got1 !== e) begin errors++; $display("FAIL d1_pre got=%h exp=%h", got1, e); end
    idle(1);
    exp_q.push_back(32'hA5); rd_bus(32'h80, 1'b0);
    checks++; e = exp_q.pop_front(); if (got1 !== e) begin errors++; $display("FAIL d1_commit got=%h exp=%h", got1, e); end
    checks++; if (irq1 !== exp_irq(1'b1)) begin errors++; $display("FAIL d1_irq got=%b exp=%b", irq1, exp_irq(1'b1)); end
    idle(2);
    exp_q.push_back(32'h0); rd_bus(32'h80, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL clean_pre got=%h exp=%h", got, e); end
    checks++; if (io_irq !== exp_irq(1'b0)) begin errors++; $display("FAIL clean_irq_pre got=%b exp=%b", io_irq, exp_irq(1'b0)); end
    idle(1);
    exp_q.push_back(32'hA5); rd_bus(32'h80, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL clean_stab0 got=%h exp=%h", got, e); end
    exp_q.push_back(32'h1); rd_bus(32'h88, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL clean_status got=%h exp=%h", got, e); end
    checks++; if (io_irq !== exp_irq(1'b1)) begin errors++; $display("FAIL clean_irq got=%b exp=%b", io_irq, exp_irq(1'b1)); end
    exp_q.push_back(32'hA5); rd_bus(32'h0000_0180, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL alias_decode got=%h exp=%h", got, e); end
    exp_q.push_back(32'h0); rd_bus(32'h8C, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL unmapped got=%h exp=%h", got, e); end
    exp_q.push_back(32'h1); rd_bus(32'h88, 1'b1);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL status_rd got=%h exp=%h", got, e); end
    exp_q.push_back(32'h1); rd_bus(32'h88, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL status_noclr got=%h exp=%h", got, e); end
  endtask

  task automatic test_clear_collision();
    exp_q.push_back(32'hA5); rd_bus(32'h80, 1'b1);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL clr_read got=%h exp=%h", got, e); end
    exp_q.push_back(32'h0); rd_bus(32'h88, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL clr_status got=%h exp=%h", got, e); end
    checks++; if (io_irq !== exp_irq(1'b0)) begin errors++; $display("FAIL clr_irq got=%b exp=%b", io_irq, exp_irq(1'b0)); end
    in_port0 = 32'h0000_003C;
    idle(4);
    exp_q.push_back(32'hA5); rd_bus(32'h80, 1'b1);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL coll_read got=%h exp=%h", got, e); end
    exp_q.push_back(32'h1); rd_bus(32'h88, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL coll_flag got=%h exp=%h", got, e); end
    exp_q.push_back(32'h3C); rd_bus(32'h80, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL coll_stab0 got=%h exp=%h", got, e); end
    checks++; if (io_irq !== exp_irq(1'b1)) begin errors++; $display("FAIL coll_irq got=%b exp=%b", io_irq, exp_irq(1'b1)); end
    exp_q.push_back(32'h3C); rd_bus(32'h80, 1'b1);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL coll_clr_read got=%h exp=%h", got, e); end
    exp_q.push_back(32'h0); rd_bus(32'h88, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL coll_cleared got=%h exp=%h", got, e); end
  endtask

  task automatic test_bounce_back();
    for (int i = 0; i < 10; i++) begin
      in_port0 = (i < 2) ? 32'h0000_003F : 32'h0000_003C;
      idle(1);
      exp_q.push_back(32'h0); rd_bus(32'h88, 1'b0);
      checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL bb_status[%0d] got=%h exp=%h", i, got, e); end
      exp_q.push_back(32'h3C); rd_bus(32'h80, 1'b0);
      checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL bb_stab0[%0d] got=%h exp=%h", i, got, e); end
    end
    in_port0 = 32'h0000_0011;
    idle(4);
    exp_q.push_back(32'h3C); rd_bus(32'h80, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL bb_after_pre got=%h exp=%h", got, e); end
    idle(1);
    exp_q.push_back(32'h11); rd_bus(32'h80, 1'b1);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL bb_after_commit got=%h exp=%h", got, e); end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 10; i++) begin
      in_port1 = (i % 2 == 0) ? 32'h1 : 32'h0;
      idle(1);
      exp_q.push_back(32'h0); rd_bus(32'h88, 1'b0);
      checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL bnc_status[%0d] got=%h exp=%h", i, got, e); end
    end
    in_port1 = 32'h1;
    idle(4);
    exp_q.push_back(32'h0); rd_bus(32'h84, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL bnc_pre got=%h exp=%h", got, e); end
    idle(1);
    exp_q.push_back(32'h1); rd_bus(32'h84, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL bnc_stab1 got=%h exp=%h", got, e); end
    exp_q.push_back(32'h2); rd_bus(32'h88, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL bnc_status_commit got=%h exp=%h", got, e); end
    checks++; if (io_irq !== exp_irq(1'b1)) begin errors++; $display("FAIL bnc_irq got=%b exp=%b", io_irq, exp_irq(1'b1)); end
    exp_q.push_back(32'h11); rd_bus(32'h80, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL bnc_indep_stab0 got=%h exp=%h", got, e); end
  endtask

  task automatic test_independent();
    in_port0 = 32'h0000_0022;
    idle(2);
    in_port1 = 32'h0000_0033;
    idle(3);
    exp_q.push_back(32'h22); rd_bus(32'h80, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL ind_stab0 got=%h exp=%h", got, e); end
    exp_q.push_back(32'h1); rd_bus(32'h84, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL ind_stab1_pre got=%h exp=%h", got, e); end
    idle(2);
    exp_q.push_back(32'h33); rd_bus(32'h84, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL ind_stab1 got=%h exp=%h", got, e); end
    exp_q.push_back(32'h3); rd_bus(32'h88, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL ind_status got=%h exp=%h", got, e); end
    rd_bus(32'h80, 1'b1);
    exp_q.push_back(32'h2); rd_bus(32'h88, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL ind_clr0 got=%h exp=%h", got, e); end
    rd_bus(32'h84, 1'b1);
    exp_q.push_back(32'h0); rd_bus(32'h88, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL ind_clr1 got=%h exp=%h", got, e); end
    checks++; if (io_irq !== exp_irq(1'b0)) begin errors++; $display("FAIL ind_irq got=%b exp=%b", io_irq, exp_irq(1'b0)); end
  endtask

  task automatic test_reset_settling();
    in_port0 = 32'h0000_0077;
    idle(2);
    reset = 1'b1; in_port0 = '0; in_port1 = '0;
    idle(1);
    exp_q.push_back(32'h0); rd_bus(32'h80, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL rs_in_reset got=%h exp=%h", got, e); end
    checks++; if (io_irq !== 1'b0) begin errors++; $display("FAIL rs_irq got=%b exp=0", io_irq); end
    reset = 1'b0;
    idle(8);
    exp_q.push_back(32'h0); rd_bus(32'h80, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL rs_stab0 got=%h exp=%h", got, e); end
    exp_q.push_back(32'h0); rd_bus(32'h88, 1'b0);
    checks++; e = exp_q.pop_front(); if (got !== e) begin errors++; $display("FAIL rs_status got=%h exp=%h", got, e); end
  endtask

  initial begin
    reset = 1'b1; rd = 1'b0; addr = '0; in_port0 = '0; in_port1 = '0;
    @(negedge io_clk);
    test_reset();
    test_clean_edge();
    test_clear_collision();
    test_bounce_back();
    test_bounce();
    test_independent();
    test_reset_settling();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
